// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2-to-matrix keyboard bridge: scancode
// prefixes, modifier codes, decoder states, autotype entry layout and the
// scancode to (row, col) matrix map.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_LALT   = 8'h11;
    localparam logic [7:0] SC_F11    = 8'h78;

    // Bytes swallowed after an E1 prefix (Pause sequence tail)
    localparam int unsigned SKIP_BYTES = 7;

    localparam logic [7:0] AT_DELAY = 8'h00;
    localparam logic [7:0] AT_END   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } dec_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] row;
        logic [2:0] col;
    } key_pos_t;

    typedef struct packed {
        logic       press;
        logic [2:0] col;
        logic [3:0] row;
    } at_entry_t;

    // Matrix position for {ext, code}; valid = 0 for unmapped codes
    function automatic key_pos_t key_map(input logic ext, input logic [7:0] code);
        key_pos_t   p;
        logic [6:0] rc;
        p  = '0;
        rc = '0;
        p.valid = 1'b1;
        case ({ext, code})
            9'h045: rc = {4'd0, 3'd0};
            9'h016: rc = {4'd0, 3'd1};
            9'h01E: rc = {4'd0, 3'd2};
            9'h026: rc = {4'd0, 3'd3};
            9'h025: rc = {4'd0, 3'd4};
            9'h02E: rc = {4'd0, 3'd5};
            9'h036: rc = {4'd0, 3'd6};
            9'h03D: rc = {4'd0, 3'd7};
            9'h03E: rc = {4'd1, 3'd0};
            9'h046: rc = {4'd1, 3'd1};
            9'h05A: rc = {4'd1, 3'd2};
            9'h04E: rc = {4'd1, 3'd3};
            9'h055: rc = {4'd1, 3'd4};
            9'h05D: rc = {4'd1, 3'd5};
            9'h054: rc = {4'd1, 3'd6};
            9'h05B: rc = {4'd1, 3'd7};
            9'h04C: rc = {4'd2, 3'd0};
            9'h052: rc = {4'd2, 3'd1};
            9'h00E: rc = {4'd2, 3'd2};
            9'h041: rc = {4'd2, 3'd3};
            9'h049: rc = {4'd2, 3'd4};
            9'h04A: rc = {4'd2, 3'd5};
            9'h061: rc = {4'd2, 3'd6};
            9'h066: rc = {4'd2, 3'd7};
            9'h032: rc = {4'd3, 3'd0};
            9'h021: rc = {4'd3, 3'd1};
            9'h023: rc = {4'd3, 3'd2};
            9'h024: rc = {4'd3, 3'd3};
            9'h02B: rc = {4'd3, 3'd4};
            9'h034: rc = {4'd3, 3'd5};
            9'h033: rc = {4'd3, 3'd6};
            9'h043: rc = {4'd3, 3'd7};
            9'h03B: rc = {4'd4, 3'd0};
            9'h01C: rc = {4'd4, 3'd1};
            9'h042: rc = {4'd4, 3'd2};
            9'h04B: rc = {4'd4, 3'd3};
            9'h03A: rc = {4'd4, 3'd4};
            9'h031: rc = {4'd4, 3'd5};
            9'h044: rc = {4'd4, 3'd6};
            9'h04D: rc = {4'd4, 3'd7};
            9'h015: rc = {4'd5, 3'd0};
            9'h02D: rc = {4'd5, 3'd1};
            9'h01B: rc = {4'd5, 3'd2};
            9'h02C: rc = {4'd5, 3'd3};
            9'h03C: rc = {4'd5, 3'd4};
            9'h02A: rc = {4'd5, 3'd5};
            9'h01D: rc = {4'd5, 3'd6};
            9'h022: rc = {4'd5, 3'd7};
            9'h035: rc = {4'd6, 3'd0};
            9'h01A: rc = {4'd6, 3'd1};
            9'h029: rc = {4'd6, 3'd2};
            9'h00D: rc = {4'd6, 3'd3};
            9'h076: rc = {4'd6, 3'd4};
            9'h005: rc = {4'd6, 3'd5};
            9'h006: rc = {4'd6, 3'd6};
            9'h004: rc = {4'd6, 3'd7};
            9'h00C: rc = {4'd7, 3'd0};
            9'h003: rc = {4'd7, 3'd1};
            9'h00B: rc = {4'd7, 3'd2};
            9'h083: rc = {4'd7, 3'd3};
            9'h00A: rc = {4'd7, 3'd4};
            9'h001: rc = {4'd7, 3'd5};
            9'h009: rc = {4'd7, 3'd6};
            9'h058: rc = {4'd7, 3'd7};
            9'h175: rc = {4'd8, 3'd0};
            9'h172: rc = {4'd8, 3'd1};
            9'h16B: rc = {4'd8, 3'd2};
            9'h174: rc = {4'd8, 3'd3};
            9'h16C: rc = {4'd8, 3'd4};
            9'h170: rc = {4'd8, 3'd5};
            9'h171: rc = {4'd8, 3'd6};
            9'h15A: rc = {4'd8, 3'd7};
            9'h012: rc = {4'd9, 3'd0};
            9'h059: rc = {4'd9, 3'd1};
            9'h014: rc = {4'd9, 3'd2};
            9'h011: rc = {4'd9, 3'd3};
            9'h07E: rc = {4'd9, 3'd4};
            9'h111: rc = {4'd9, 3'd5};
            9'h114: rc = {4'd9, 3'd6};
            9'h07D: rc = {4'd9, 3'd7};
            9'h078: rc = {4'd10, 3'd0};
            9'h007: rc = {4'd10, 3'd1};
            default: p.valid = 1'b0;
        endcase
        p.row = rc[6:3];
        p.col = rc[2:0];
        return p;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver.
// Synchronises ps2_clk/ps2_dat, qualifies a falling edge as four high samples
// followed by one low sample, assembles the 11-bit frame and checks start,
// odd parity and stop. A partial frame idle for TIMEOUT_CYC clocks is dropped
// silently.
// Ports: clk, reset_n (async, active-low), ps2_clk/ps2_dat (raw lines),
//        data/valid (one-cycle byte strobe), frame_err (one-cycle pulse).
module ps2_rx #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [3:0]    clk_hist;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;
    logic          fall_c;
    logic          frame_ok_c;

    // Qualified falling edge of the synchronised PS/2 clock
    assign fall_c = (clk_hist == 4'hF) && !clk_sync[1];

    // shreg holds {parity, d7..d0, start}; the stop bit is the live sample
    assign frame_ok_c = !shreg[0] && (^shreg[9:1]) && dat_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '0;
            dat_sync  <= '0;
            clk_hist  <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_dat};
            clk_hist  <= {clk_hist[2:0], clk_sync[1]};
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (fall_c) begin
                idle_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt   <= '0;
                    data      <= shreg[8:1];
                    valid     <= frame_ok_c;
                    frame_err <= !frame_ok_c;
                end else begin
                    shreg   <= {dat_sync[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != '0) begin
                // Stalled partial frame: drop it without flagging an error
                if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    bit_cnt  <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard to row/column key matrix bridge.
// Decodes PS/2 set-2 scancodes into a ROWS x COLS key state matrix read back
// through a row-select mask, tracks modifiers and an F11 reset chord, and
// optionally replays an autotype sequence into the matrix.
// Ports: clk, reset_n (async, active-low), ps2_clk/ps2_dat (raw PS/2),
//        sel (row mask) -> odata (combinational column OR), mods {alt,ctrl,shift},
//        reset_key {shift&F11, (ctrl|shift)&F11}, frame_err (pulse),
//        at_valid/at_code/at_ready (autotype entry handshake), auto_busy.
// Config: define PS2_MATRIX_AUTOTYPE_EN to build the autotype engine; without
//         it at_ready/auto_busy are tied low and at_valid/at_code are ignored.
module ps2_matrix_kbd
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned ROWS        = 11,
    parameter int unsigned COLS        = 8,
    parameter int unsigned ACTIVE_LOW  = 0,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned STROBE_DIV  = 3000000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ps2_clk,
    input  logic            ps2_dat,
    input  logic [ROWS-1:0] sel,
    output logic [COLS-1:0] odata,
    output logic [2:0]      mods,
    output logic [1:0]      reset_key,
    output logic            frame_err,
    input  logic            at_valid,
    input  logic [7:0]      at_code,
    output logic            at_ready,
    output logic            auto_busy
);

    logic [7:0] rx_data;
    logic       rx_valid;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (frame_err)
    );

    dec_state_t                 state;
    logic [2:0]                 skip_cnt;
    logic [ROWS-1:0][COLS-1:0]  keystate;
    logic shift_l, shift_r, ctrl_l, ctrl_r, alt_l;
    logic shift_l_n, shift_r_n, ctrl_l_n, ctrl_r_n, alt_l_n;

    logic      ev_c;
    logic      ev_ext_c;
    logic      ev_brk_c;
    key_pos_t  pos_c;

    at_entry_t at_ent;
    logic      at_wr_c;
    logic      at_clr_c;
    logic      kbd_lock;

`ifdef PS2_MATRIX_AUTOTYPE_EN
    localparam int unsigned DW = $clog2(STROBE_DIV + 1);

    logic          at_pend;
    logic [DW-1:0] dly_cnt;
    logic          at_accept_c;

    assign at_accept_c = at_valid && at_ready;
    assign at_clr_c    = at_accept_c;
    assign at_wr_c     = at_pend && (8'(at_ent) != AT_DELAY) && (8'(at_ent) != AT_END);
    assign kbd_lock    = auto_busy;

    // Autotype pacing: accept one entry, apply it next cycle, hold off STROBE_DIV clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            at_ready  <= 1'b0;
            auto_busy <= 1'b0;
            at_pend   <= 1'b0;
            at_ent    <= '0;
            dly_cnt   <= '0;
        end else begin
            at_pend <= at_accept_c;
            if (at_accept_c) begin
                at_ent    <= at_entry_t'(at_code);
                auto_busy <= 1'b1;
                at_ready  <= 1'b0;
                dly_cnt   <= DW'(STROBE_DIV);
            end else if (dly_cnt != '0) begin
                dly_cnt <= dly_cnt - DW'(1);
                if (dly_cnt == DW'(1)) begin
                    at_ready <= 1'b1;
                end
            end else begin
                at_ready <= 1'b1;
            end
            if (at_pend && (8'(at_ent) == AT_END)) begin
                auto_busy <= 1'b0;
            end
        end
    end
`else
    logic unused_at;

    assign unused_at = ^{at_valid, at_code, 32'(STROBE_DIV)};
    assign at_ready  = 1'b0;
    assign auto_busy = 1'b0;
    assign at_ent    = '0;
    assign at_wr_c   = 1'b0;
    assign at_clr_c  = 1'b0;
    assign kbd_lock  = 1'b0;
`endif

    // Non-prefix byte outside a Pause sequence is a key event
    always_comb begin
        ev_c     = rx_valid && (state != ST_SKIP) &&
                   (rx_data != SC_EXT) && (rx_data != SC_BRK) && (rx_data != SC_PAUSE);
        ev_ext_c = (state == ST_EXT) || (state == ST_EXT_BRK);
        ev_brk_c = (state == ST_BRK) || (state == ST_EXT_BRK);
        pos_c    = key_map(ev_ext_c, rx_data);
    end

    // Modifier next state; E0 12 (fake shift) is deliberately not a shift
    always_comb begin
        shift_l_n = shift_l;
        shift_r_n = shift_r;
        ctrl_l_n  = ctrl_l;
        ctrl_r_n  = ctrl_r;
        alt_l_n   = alt_l;
        if (ev_c && !ev_ext_c) begin
            case (rx_data)
                SC_LSHIFT: shift_l_n = !ev_brk_c;
                SC_RSHIFT: shift_r_n = !ev_brk_c;
                SC_CTRL:   ctrl_l_n  = !ev_brk_c;
                SC_LALT:   alt_l_n   = !ev_brk_c;
                default:   ;
            endcase
        end
        if (ev_c && ev_ext_c && (rx_data == SC_CTRL)) begin
            ctrl_r_n = !ev_brk_c;
        end
        if (at_clr_c) begin
            shift_l_n = 1'b0;
            shift_r_n = 1'b0;
            ctrl_l_n  = 1'b0;
            ctrl_r_n  = 1'b0;
            alt_l_n   = 1'b0;
        end
    end

    // Scancode decoder FSM, modifiers, reset chord and key matrix
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            keystate  <= '0;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            ctrl_l    <= 1'b0;
            ctrl_r    <= 1'b0;
            alt_l     <= 1'b0;
            mods      <= '0;
            reset_key <= '0;
        end else begin
            if (rx_valid) begin
                if (state == ST_SKIP) begin
                    if (skip_cnt == 3'(SKIP_BYTES - 1)) begin
                        state <= ST_IDLE;
                    end
                    skip_cnt <= skip_cnt + 3'd1;
                end else if (rx_data == SC_PAUSE) begin
                    state    <= ST_SKIP;
                    skip_cnt <= '0;
                end else if (rx_data == SC_EXT) begin
                    state <= ST_EXT;
                end else if (rx_data == SC_BRK) begin
                    state <= ev_ext_c ? ST_EXT_BRK : ST_BRK;
                end else begin
                    state <= ST_IDLE;
                end
            end

            shift_l <= shift_l_n;
            shift_r <= shift_r_n;
            ctrl_l  <= ctrl_l_n;
            ctrl_r  <= ctrl_r_n;
            alt_l   <= alt_l_n;
            mods    <= {alt_l_n, ctrl_l_n | ctrl_r_n, shift_l_n | shift_r_n};

            // Chord latched from the modifiers held when F11 goes down
            if (ev_c && !ev_ext_c && (rx_data == SC_F11)) begin
                reset_key <= ev_brk_c ? 2'b00 : {mods[0], mods[1] | mods[0]};
            end

            // Autotype write is last so it wins a same-cycle collision
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (ev_c && !kbd_lock && pos_c.valid &&
                        (pos_c.row == 4'(r)) && (pos_c.col == 3'(c))) begin
                        keystate[r][c] <= !ev_brk_c;
                    end
                    if (at_wr_c && (at_ent.row == 4'(r)) && (at_ent.col == 3'(c))) begin
                        keystate[r][c] <= at_ent.press;
                    end
                end
            end
        end
    end

    // Column readback: OR of selected rows, zero latency from sel
    always_comb begin
        logic [COLS-1:0] acc;
        acc = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (sel[r]) begin
                acc = acc | keystate[r];
            end
        end
        odata = (ACTIVE_LOW != 0) ? ~acc : acc;
    end

endmodule
